datapath_seq: RTL and testbench

Parametrised, self-sequencing successor to the lab datapath. One register file of NREG×W words, A/B operand registers, a shifter, a 2-bit-op ALU, C and status registers, plus a built-in sequencer that accepts one operation per valid/ready handshake, runs the read-A / read-B / execute / write-back steps itself, and pulses `done`. It sits between the instruction decoder/controller and memory, and frees the controller FSM from issuing individual load enables.

---
 rtl/datapath_seq_pkg.sv | 40 ++++
 rtl/datapath_seq_if.sv | 52 +++++
 rtl/datapath_seq_regfile_p.sv | 48 ++++
 rtl/datapath_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_datapath_seq.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : datapath_seq_pkg                                        |
// | Description : Shared types and codes for the self-sequencing          |
// |               datapath: FSM state enum, ALU-op / shift / write-back   |
// |               source codes and status bit positions.                  |
// | Config      : DATAPATH_SEQ_FAST_EN (the RDB state is unused when set) |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package datapath_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDA  = 3'd1,
    ST_RDB  = 3'd2,
    ST_EX   = 3'd3,
    ST_WB   = 3'd4
  } state_e;

  localparam logic [1:0] c_alu_add  = 2'b00;
  localparam logic [1:0] c_alu_sub  = 2'b01;
  localparam logic [1:0] c_alu_and  = 2'b10;
  localparam logic [1:0] c_alu_notb = 2'b11;

  localparam logic [1:0] c_sh_none = 2'b00;
  localparam logic [1:0] c_sh_lsl  = 2'b01;
  localparam logic [1:0] c_sh_lsr  = 2'b10;
  localparam logic [1:0] c_sh_asr  = 2'b11;

  localparam logic [1:0] c_vsel_mdata = 2'b00;
  localparam logic [1:0] c_vsel_imm8  = 2'b01;
  localparam logic [1:0] c_vsel_pc    = 2'b10;
  localparam logic [1:0] c_vsel_c     = 2'b11;

  localparam int c_stat_z = 0;
  localparam int c_stat_n = 1;
  localparam int c_stat_v = 2;

endpackage
`default_nettype wire

// File: rtl/datapath_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : datapath_seq_if                                         |
// | Description : Request/response bundle between controller (master)    |
// |               and datapath_seq (slave).                               |
// | Ports       : req_valid/req_ready handshake, req_* operation fields,  |
// |               mdata/sximm8/sximm5/pc operands, done pulse, c, status. |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface datapath_seq_if #(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int PCW  = 9
);
  localparam int RW = $clog2(NREG);

  logic          req_valid;
  logic          req_ready;
  logic [RW-1:0] req_rd;
  logic [RW-1:0] req_rn;
  logic [RW-1:0] req_rm;
  logic [1:0]    req_aluop;
  logic [1:0]    req_shift;
  logic          req_asel;
  logic          req_bsel;
  logic [1:0]    req_vsel;
  logic          req_wb;
  logic          req_loads;
  logic [W-1:0]  mdata;
  logic [W-1:0]  sximm8;
  logic [W-1:0]  sximm5;
  logic [PCW-1:0] pc;
  logic          done;
  logic [W-1:0]  c;
  logic [2:0]    status;

  modport master (
    output req_valid, req_rd, req_rn, req_rm, req_aluop, req_shift,
           req_asel, req_bsel, req_vsel, req_wb, req_loads,
           mdata, sximm8, sximm5, pc,
    input  req_ready, done, c, status
  );

  modport slave (
    input  req_valid, req_rd, req_rn, req_rm, req_aluop, req_shift,
           req_asel, req_bsel, req_vsel, req_wb, req_loads,
           mdata, sximm8, sximm5, pc,
    output req_ready, done, c, status
  );

endinterface
`default_nettype wire

// File: rtl/datapath_seq_regfile_p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : regfile_p                                               |
// | Description : NREG x W register file, synchronous write, combinational|
// |               read. Synchronous reset clears every entry.            |
// | Ports       : clk, reset, we/waddr/wdata (write port),                |
// |               raddr0/rdata0 (read port 0),                           |
// |               raddr1/rdata1 (read port 1, only with                  |
// |               DATAPATH_SEQ_FAST_EN defined)                           |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module regfile_p #(
  parameter int W    = 16,
  parameter int NREG = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(NREG)-1:0]  waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(NREG)-1:0]  raddr0,
`ifdef DATAPATH_SEQ_FAST_EN
  input  logic [$clog2(NREG)-1:0]  raddr1,
  output logic [W-1:0]             rdata1,
`endif
  output logic [W-1:0]             rdata0
);

  logic [W-1:0] r_mem [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata0 = r_mem[raddr0];

`ifdef DATAPATH_SEQ_FAST_EN
  assign rdata1 = r_mem[raddr1];
`endif

endmodule
`default_nettype wire

// File: rtl/datapath_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : datapath_seq                                            |
// | Description : Self-sequencing datapath. Accepts one operation per     |
// |               valid/ready handshake, then runs read-A, read-B,        |
// |               execute and write-back on its own, pulsing done in WB.  |
// | Ports       : clk, reset (sync, active high), bus (datapath_seq_if    |
// |               slave: request fields, operands, ready, done, c,       |
// |               status[0]=Z [1]=N [2]=V)                                |
// | Config      : DATAPATH_SEQ_FAST_EN - dual-read register file, A and B |
// |               loaded together in RDA, RDB skipped.                    |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int PCW  = 9
) (
  input  logic         clk,
  input  logic         reset,
  datapath_seq_if.slave bus
);

  localparam int RW = $clog2(NREG);

  state_e r_state;
  state_e w_state_next;

  // Captured request; the bus is ignored outside IDLE.
  logic [RW-1:0]  r_rd, r_rn, r_rm;
  logic [1:0]     r_aluop, r_shift, r_vsel;
  logic           r_asel, r_bsel, r_wb, r_loads;
  logic [W-1:0]   r_mdata, r_sximm8, r_sximm5;
  logic [PCW-1:0] r_pc;

  logic [W-1:0]   r_a, r_b, r_c;
  logic [2:0]     r_status;

  logic           w_ready, w_done, w_load_a, w_load_b, w_exec, w_write;
  logic           w_accept;
  logic [RW-1:0]  w_raddr0;
  logic [W-1:0]   w_rdata0;
  logic [W-1:0]   w_b_loaded;
  logic [W-1:0]   w_bsh, w_ain, w_bin, w_alu, w_wdata;
  logic           w_ovf;
  logic [2:0]     w_status_next;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.req_valid) w_state_next = ST_RDA;
`ifdef DATAPATH_SEQ_FAST_EN
      ST_RDA:  w_state_next = ST_EX;
`else
      ST_RDA:  w_state_next = ST_RDB;
`endif
      ST_RDB:  w_state_next = ST_EX;
      ST_EX:   w_state_next = ST_WB;
      ST_WB:   w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_ready  = 1'b0;
    w_done   = 1'b0;
    w_load_a = 1'b0;
    w_load_b = 1'b0;
    w_exec   = 1'b0;
    w_write  = 1'b0;
    case (r_state)
      ST_IDLE: w_ready = 1'b1;
      ST_RDA: begin
        w_load_a = 1'b1;
`ifdef DATAPATH_SEQ_FAST_EN
        w_load_b = 1'b1;
`endif
      end
      ST_RDB:  w_load_b = 1'b1;
      ST_EX:   w_exec   = 1'b1;
      ST_WB: begin
        w_done  = 1'b1;
        w_write = r_wb;
      end
      default: ;
    endcase
  end

  assign w_accept = w_ready & bus.req_valid;

  // ---------------- register file ----------------
`ifdef DATAPATH_SEQ_FAST_EN
  logic [W-1:0] w_rdata1;
  assign w_raddr0   = r_rn;
  assign w_b_loaded = w_rdata1;

  regfile_p #(.W(W), .NREG(NREG)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (w_write),
    .waddr  (r_rd),
    .wdata  (w_wdata),
    .raddr0 (w_raddr0),
    .raddr1 (r_rm),
    .rdata1 (w_rdata1),
    .rdata0 (w_rdata0)
  );
`else
  // Single read port: the address follows whichever operand is being loaded.
  assign w_raddr0   = w_load_b ? r_rm : r_rn;
  assign w_b_loaded = w_rdata0;

  regfile_p #(.W(W), .NREG(NREG)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (w_write),
    .waddr  (r_rd),
    .wdata  (w_wdata),
    .raddr0 (w_raddr0),
    .rdata0 (w_rdata0)
  );
`endif

  // ---------------- shifter / ALU / status ----------------
  always_comb begin
    case (r_shift)
      c_sh_lsl: w_bsh = {r_b[W-2:0], 1'b0};
      c_sh_lsr: w_bsh = {1'b0, r_b[W-1:1]};
      c_sh_asr: w_bsh = {r_b[W-1], r_b[W-1:1]};
      default:  w_bsh = r_b;
    endcase
  end

  assign w_ain = r_asel ? '0 : r_a;
  assign w_bin = r_bsel ? r_sximm5 : w_bsh;

  always_comb begin
    w_ovf = 1'b0;
    case (r_aluop)
      c_alu_add: begin
        w_alu = w_ain + w_bin;
        w_ovf = (w_ain[W-1] == w_bin[W-1]) && (w_alu[W-1] != w_ain[W-1]);
      end
      c_alu_sub: begin
        w_alu = w_ain - w_bin;
        w_ovf = (w_ain[W-1] != w_bin[W-1]) && (w_alu[W-1] != w_ain[W-1]);
      end
      c_alu_and: w_alu = w_ain & w_bin;
      default:   w_alu = ~w_bin;
    endcase
  end

  always_comb begin
    w_status_next           = '0;
    w_status_next[c_stat_z] = (w_alu == '0);
    w_status_next[c_stat_n] = w_alu[W-1];
    w_status_next[c_stat_v] = w_ovf;
  end

  // ---------------- write-back mux ----------------
  always_comb begin
    case (r_vsel)
      c_vsel_mdata: w_wdata = r_mdata;
      c_vsel_imm8:  w_wdata = r_sximm8;
      c_vsel_pc:    w_wdata = W'(r_pc);
      default:      w_wdata = r_c;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd     <= '0;
      r_rn     <= '0;
      r_rm     <= '0;
      r_aluop  <= '0;
      r_shift  <= '0;
      r_vsel   <= '0;
      r_asel   <= 1'b0;
      r_bsel   <= 1'b0;
      r_wb     <= 1'b0;
      r_loads  <= 1'b0;
      r_mdata  <= '0;
      r_sximm8 <= '0;
      r_sximm5 <= '0;
      r_pc     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_status <= '0;
    end else begin
      if (w_accept) begin
        r_rd     <= bus.req_rd;
        r_rn     <= bus.req_rn;
        r_rm     <= bus.req_rm;
        r_aluop  <= bus.req_aluop;
        r_shift  <= bus.req_shift;
        r_vsel   <= bus.req_vsel;
        r_asel   <= bus.req_asel;
        r_bsel   <= bus.req_bsel;
        r_wb     <= bus.req_wb;
        r_loads  <= bus.req_loads;
        r_mdata  <= bus.mdata;
        r_sximm8 <= bus.sximm8;
        r_sximm5 <= bus.sximm5;
        r_pc     <= bus.pc;
      end
      if (w_load_a) r_a <= w_rdata0;
      if (w_load_b) r_b <= w_b_loaded;
      if (w_exec) begin
        r_c <= w_alu;
        if (r_loads) r_status <= w_status_next;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.done      = w_done;
  assign bus.c         = r_c;
  assign bus.status    = r_status;

endmodule
`default_nettype wire

// File: tb/tb_datapath_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_datapath_seq                                         |
// | Description : Self-checking bench for datapath_seq. A reference model |
// |               computes each operation's C/status when it is accepted  |
// |               and queues it; the entry is popped and compared at done.|
// | Config      : DATAPATH_SEQ_FAST_EN selects the shorter latency.       |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_datapath_seq;

`ifdef DATAPATH_SEQ_FAST_EN
  localparam int EXP_LAT = 2;  // clock edges from accept edge to done
`else
  localparam int EXP_LAT = 3;
`endif
  localparam int EXP_GAP = EXP_LAT + 2;  // accept-to-accept, back to back

  typedef struct {
    logic [2:0]  rd, rn, rm;
    logic [1:0]  aluop, shift, vsel;
    logic        asel, bsel, wb, loads;
    logic [15:0] mdata, imm8, imm5;
    logic [8:0]  pc;
  } op_t;

  typedef struct {
    logic [15:0] c;
    logic [2:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_accept = 0;

  logic [15:0] m_r [8];
  logic [15:0] m_c;
  logic [2:0]  m_st;
  exp_t        sb_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  datapath_seq_if #(.W(16), .NREG(8), .PCW(9)) bus ();

  datapath_seq #(.W(16), .NREG(8), .PCW(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic op_t op_nop();
    op_t o;
    o.rd = 0; o.rn = 0; o.rm = 0; o.aluop = 0; o.shift = 0; o.vsel = 0;
    o.asel = 0; o.bsel = 0; o.wb = 0; o.loads = 0;
    o.mdata = 0; o.imm8 = 0; o.imm5 = 0; o.pc = 0;
    return o;
  endfunction

  function automatic op_t op_imm(logic [2:0] rd, logic [15:0] v);
    op_t o = op_nop();
    o.rd = rd; o.vsel = 2'b01; o.imm8 = v; o.wb = 1'b1;
    return o;
  endfunction

  // C <- R[rn] + 0, no write-back: used to observe a register.
  function automatic op_t op_read(logic [2:0] rn);
    op_t o = op_nop();
    o.rn = rn; o.bsel = 1'b1; o.imm5 = 16'h0000;
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
    m_c  = 16'h0;
    m_st = 3'b000;
    sb_q.delete();
  endtask

  task automatic model_push(input op_t o);
    logic [15:0] a, b, bs, ain, bin, res, wv;
    int sa, sb, s;
    logic v;
    a = m_r[o.rn];
    b = m_r[o.rm];
    case (o.shift)
      2'b01:   bs = b << 1;
      2'b10:   bs = b >> 1;
      2'b11:   bs = 16'($signed(b) >>> 1);
      default: bs = b;
    endcase
    ain = o.asel ? 16'h0 : a;
    bin = o.bsel ? o.imm5 : bs;
    sa = int'($signed(ain));
    sb = int'($signed(bin));
    v = 1'b0;
    case (o.aluop)
      2'b00: begin res = ain + bin; s = sa + sb; v = (s > 32767) || (s < -32768); end
      2'b01: begin res = ain - bin; s = sa - sb; v = (s > 32767) || (s < -32768); end
      2'b10: res = ain & bin;
      default: res = ~bin;
    endcase
    m_c = res;
    if (o.loads) m_st = {v, res[15], (res == 16'h0)};
    case (o.vsel)
      2'b00:   wv = o.mdata;
      2'b01:   wv = o.imm8;
      2'b10:   wv = {7'h0, o.pc};
      default: wv = m_c;
    endcase
    if (o.wb) m_r[o.rd] = wv;
    sb_q.push_back('{c: m_c, st: m_st});
  endtask

  task automatic drive(input op_t o);
    bus.req_rd = o.rd; bus.req_rn = o.rn; bus.req_rm = o.rm;
    bus.req_aluop = o.aluop; bus.req_shift = o.shift; bus.req_vsel = o.vsel;
    bus.req_asel = o.asel; bus.req_bsel = o.bsel; bus.req_wb = o.wb;
    bus.req_loads = o.loads; bus.mdata = o.mdata; bus.sximm8 = o.imm8;
    bus.sximm5 = o.imm5; bus.pc = o.pc;
  endtask

  // Waits (bounded) for done, then checks latency and pops the scoreboard.
  task automatic wait_done_check(input string name);
    exp_t e;
    int k = 0;
    while (bus.done !== 1'b1 && k < 12) begin
      @(posedge clk); #1; k++;
    end
    checks++;
    if (k != EXP_LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d edges required %0d", name, k, EXP_LAT);
    end
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue required one entry", name);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (bus.c !== e.c) begin
      errors++;
      $display("FAIL %s c: got %h required %h", name, bus.c, e.c);
    end
    checks++;
    if (bus.status !== e.st) begin
      errors++;
      $display("FAIL %s status: got %b required %b", name, bus.status, e.st);
    end
  endtask

  // Issue one op; returns at the done cycle (posedge+1) so the next call
  // can follow back to back.
  task automatic do_op(input op_t o, input string name);
    int n = 0;
    drive(o);
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL %s ready: got 0 required 1", name);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_push(o);
    #1;
    last_accept = cyc;
    bus.req_valid = 1'b0;
    wait_done_check(name);
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0;
    drive(op_nop());
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    checks++; if (bus.c !== 16'h0)      begin errors++; $display("FAIL reset c: got %h required 0000", bus.c); end
    checks++; if (bus.status !== 3'b0)  begin errors++; $display("FAIL reset status: got %b required 000", bus.status); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b required 1", bus.req_ready); end
    checks++; if (bus.done !== 1'b0)    begin errors++; $display("FAIL reset done: got %b required 0", bus.done); end
  endtask

  task automatic test_imm_write();
    op_t o;
    do_op(op_imm(3'd3, 16'h0042), "imm_write");
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b required 0", bus.done); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_wb: got %b required 1", bus.req_ready); end
    o = op_read(3'd3);
    do_op(o, "imm_readback");
  endtask

  task automatic test_add();
    op_t o;
    do_op(op_imm(3'd1, 16'd5), "add_setup_r1");
    do_op(op_imm(3'd2, 16'd7), "add_setup_r2");
    o = op_nop();
    o.rn = 1; o.rm = 2; o.aluop = 2'b00; o.loads = 1; o.vsel = 2'b11; o.rd = 4; o.wb = 1;
    do_op(o, "add");
    do_op(op_read(3'd4), "add_r4_readback");
  endtask

  task automatic test_sub_overflow();
    op_t o;
    do_op(op_imm(3'd1, 16'd5), "sub_setup");
    o = op_nop();
    o.rn = 1; o.rm = 1; o.aluop = 2'b01; o.loads = 1;
    do_op(o, "sub_zero");
    do_op(op_imm(3'd1, 16'h7FFF), "ovf_setup_r1");
    do_op(op_imm(3'd2, 16'h0001), "ovf_setup_r2");
    o = op_nop();
    o.rn = 1; o.rm = 2; o.aluop = 2'b00; o.loads = 1;
    do_op(o, "add_ovf");
    do_op(op_imm(3'd1, 16'h8000), "subovf_setup");
    o.aluop = 2'b01;
    do_op(o, "sub_ovf");
    o.aluop = 2'b10;
    do_op(o, "and_flags");
    o.aluop = 2'b11;
    do_op(o, "notb_flags");
  endtask

  task automatic test_shift();
    op_t o;
    do_op(op_imm(3'd2, 16'h8004), "shift_setup");
    o = op_nop();
    o.rm = 2; o.asel = 1; o.aluop = 2'b00;
    o.shift = 2'b11; do_op(o, "asr");
    o.shift = 2'b10; do_op(o, "lsr");
    o.shift = 2'b01; do_op(o, "lsl");
  endtask

  task automatic test_vsel();
    op_t o;
    o = op_nop(); o.rd = 6; o.vsel = 2'b00; o.mdata = 16'hBEEF; o.wb = 1;
    do_op(o, "vsel_mdata");
    do_op(op_read(3'd6), "vsel_mdata_rb");
    o = op_nop(); o.rd = 7; o.vsel = 2'b10; o.pc = 9'h1A5; o.wb = 1;
    do_op(o, "vsel_pc");
    do_op(op_read(3'd7), "vsel_pc_rb");
  endtask

  task automatic test_back_to_back();
    int first;
    do_op(op_imm(3'd5, 16'h0A0A), "b2b_first");
    first = last_accept;
    do_op(op_read(3'd5), "b2b_second");
    checks++;
    if (last_accept - first != EXP_GAP) begin
      errors++;
      $display("FAIL b2b_gap: got %0d cycles required %0d", last_accept - first, EXP_GAP);
    end
  endtask

  task automatic test_busy_ignore();
    op_t a, b;
    int n = 0;
    int dn = 0;
    do_op(op_imm(3'd1, 16'h0011), "busy_setup");
    @(posedge clk); #1;
    a = op_read(3'd1);
    b = op_nop(); b.rd = 1; b.aluop = 2'b11; b.bsel = 1; b.imm5 = 16'h0055;
    b.loads = 1; b.wb = 1; b.vsel = 2'b01; b.imm8 = 16'hDEAD;
    drive(a);
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk);
    model_push(a);
    #1;
    drive(b);  // valid held high with different fields while busy
    wait_done_check("busy_ignore");
    bus.req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin errors++; $display("FAIL busy_not_queued: got %0d done pulses required 0", dn); end
    do_op(op_read(3'd1), "busy_r1_unchanged");
  endtask

  task automatic test_reset_mid_op();
    int dn = 0;
    int n = 0;
    drive(op_imm(3'd5, 16'h1234));
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (EXP_LAT - 1) begin @(posedge clk); #1; end
    reset = 1'b1;  // now in EX
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b required 1", bus.req_ready); end
    checks++; if (bus.c !== 16'h0) begin errors++; $display("FAIL midrst_c: got %h required 0000", bus.c); end
    repeat (4) begin
      if (bus.done === 1'b1) dn++;
      @(posedge clk); #1;
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL midrst_done: got %0d pulses required 0", dn); end
    do_op(op_read(3'd5), "midrst_r5");
  endtask

  initial begin
    bus.req_valid = 1'b0;
    drive(op_nop());
    model_reset();
    test_reset();
    test_imm_write();
    test_add();
    test_sub_overflow();
    test_shift();
    test_vsel();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
